// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the Number_Cruncher run/step controller: FSM encoding and
// opcode field positions.
package cpu_ctrl_pkg;

  localparam logic [1:0] ST_STOP = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  localparam int unsigned OP_J       = 7;
  localparam int unsigned OP_C       = 6;
  localparam int unsigned OP_TGT_MSB = 2;
  localparam int unsigned OP_TGT_LSB = 0;

  // Unconditional jump whose target is the current PC: the program has parked itself.
  function automatic logic is_self_jump(input logic [7:0] op, input logic [3:0] pc);
    return op[OP_J] && ({1'b0, op[OP_TGT_MSB:OP_TGT_LSB]} == pc);
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for an already-synchronised button level.
module edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic rise
);

  logic r_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= level;
    end
  end

  assign rise = level & ~r_prev;

endmodule

// File: rtl/run_step_controller.sv
// Run/step/halt sequencer producing a registered one-cycle instruction enable for the
// Number_Cruncher core, plus a retired-instruction counter.
module run_step_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE = 25000000,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             btn_stop,
  input  logic [3:0]       pc,
  input  logic [7:0]       op_code,
  input  logic             bp_en,
  input  logic [3:0]       bp_addr,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic             w_run_rise;
  logic             w_step_rise;
  logic             w_stop_rise;
  logic             w_issue;
  logic             w_unused_op;

  logic [1:0]       r_state,   w_state_d;
  logic             r_cpu_en,  w_cpu_en_d;
  logic [PS_W-1:0]  r_presc,   w_presc_d;
  logic             r_skip_bp, w_skip_bp_d;
  logic [CNT_W-1:0] r_count;

  edge_detect u_run_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (btn_run),
    .rise    (w_run_rise)
  );

  edge_detect u_step_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (btn_step),
    .rise    (w_step_rise)
  );

  edge_detect u_stop_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (btn_stop),
    .rise    (w_stop_rise)
  );

  // Conditional-jump and data bits play no part in sequencing decisions.
  assign w_unused_op = ^op_code[6:3];

  assign w_issue = (r_presc == PS_W'(PRESCALE - 1));

  always_comb begin
    w_state_d   = r_state;
    w_cpu_en_d  = 1'b0;
    w_presc_d   = r_presc;
    w_skip_bp_d = r_skip_bp;
    unique case (r_state)
      ST_STOP: begin
        if (w_stop_rise) begin
          w_state_d = ST_STOP;
        end else if (w_run_rise) begin
          w_state_d   = ST_RUN;
          w_presc_d   = '0;
          w_skip_bp_d = 1'b1;
        end else if (w_step_rise) begin
          w_state_d  = ST_STEP;
          w_cpu_en_d = 1'b1;
        end
      end
      ST_STEP: begin
        w_state_d = ST_STOP;
      end
      ST_RUN: begin
        w_presc_d = w_issue ? '0 : r_presc + PS_W'(1);
        if (w_stop_rise) begin
          w_state_d = ST_STOP;
        end else if (w_issue) begin
          if (bp_en && (pc == bp_addr) && !r_skip_bp) begin
            w_state_d = ST_STOP;
          end else if (is_self_jump(op_code, pc)) begin
            w_state_d = ST_HALT;
          end else begin
            w_cpu_en_d  = 1'b1;
            w_skip_bp_d = 1'b0;
          end
        end
      end
      ST_HALT: begin
        if (w_stop_rise) begin
          w_state_d = ST_STOP;
        end
      end
      default: w_state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_STOP;
      r_cpu_en  <= 1'b0;
      r_presc   <= '0;
      r_skip_bp <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_d;
      r_cpu_en  <= w_cpu_en_d;
      r_presc   <= w_presc_d;
      r_skip_bp <= w_skip_bp_d;
      if (r_cpu_en) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign cpu_en      = r_cpu_en;
  assign state       = r_state;
  assign halted      = (r_state == ST_HALT);
  assign instr_count = r_count;

endmodule

// File: doc/run_step_controller.md
Name: run_step_controller

Overview:
- Sequences execution of the 4-bit Number_Cruncher core by generating a one-clk-wide instruction enable (cpu_en) from a prescaled free-run tick, single-step requests, a PC breakpoint and jump-to-self halt detection.
- Sits between the board buttons/switches and the core; the core's PC, register and carry flops update only on cycles where cpu_en=1.
- Also keeps a retired-instruction counter for the display logic.

Parameters:
- PRESCALE, 25000000, clk cycles between instruction issues in RUN (>=2).
- CNT_W, 8, width of instr_count.

Ports:
- clk  input  1  system clock; single clock domain.
- reset_n  input  1  asynchronous, active-low reset.
- btn_run  input  1  run request, synchronised level, active-high.
- btn_step  input  1  single-step request, synchronised level, active-high.
- btn_stop  input  1  stop request, synchronised level, active-high.
- pc  input  4  current core PC.
- op_code  input  8  current instruction {J,C,D1,D0,S_reg,S_C2,C1,C0}.
- bp_en  input  1  breakpoint enable.
- bp_addr  input  4  breakpoint PC.
- cpu_en  output  1  one-cycle instruction enable to core.
- state  output  2  FSM state (STOP=0, RUN=1, STEP=2, HALT=3).
- halted  output  1  high in HALT.
- instr_count  output  CNT_W  instructions issued, modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release): state=STOP, cpu_en=0, halted=0, instr_count=0, prescaler=0, skip_bp=0, button edge registers=0.
- Buttons: rising-edge detected via registered previous level. An edge is seen in the cycle the level is first high. Priority in the same cycle: stop > run > step.
- STOP:
  - run edge -> RUN, prescaler=0, skip_bp=1.
  - step edge -> STEP.
  - cpu_en=0.
- STEP:
  - cpu_en=1 for exactly the first cycle in STEP, then STOP next cycle. Step edge at cycle k gives cpu_en=1 at k+1 and state=STOP at k+2.
  - Breakpoint and halt detection are ignored; stepping through a jump-to-self is allowed.
  - A stop edge in STEP does not cancel the pulse already issuing.
- RUN:
  - Prescaler counts 0..PRESCALE-1 and wraps. Issue point is prescaler==PRESCALE-1.
  - At the issue point, evaluate in priority order:
    - (a) bp_en && pc==bp_addr && !skip_bp -> STOP, no pulse.
    - (b) J==1 && {1'b0,op_code[2:0]}==pc -> HALT, no pulse.
    - (c) otherwise cpu_en=1 that cycle and clear skip_bp.
  - Stop edge in any RUN cycle, including the issue cycle -> STOP, no pulse.
  - Run and step edges are ignored in RUN.
- HALT:
  - halted=1, cpu_en=0.
  - Stop edge -> STOP (halted=0); run/step edges ignored.
- instr_count increments by 1 on every cycle with cpu_en=1 and wraps from 2^CNT_W-1 to 0.
- cpu_en is registered, so there is never more than one pulse per issue point and never two consecutive cycles high.
- Conditional jump (C) is never treated as a halt; carry is not visible to this block.
- Reset mid-RUN or mid-pulse drops cpu_en immediately (asynchronous).

Decomposition:
- Package cpu_ctrl_pkg:
  - state encoding constants ST_STOP/ST_RUN/ST_STEP/ST_HALT.
  - opcode field positions: OP_J=7, OP_C=6, OP_TGT=2:0.
- One sub-module edge_detect (clk, reset_n, level, rise), instanced three times for the buttons.

Test Plan (PRESCALE=4, CNT_W=8):
- Reset then btn_step pulse at cycle 10, pc=3, op_code=8'h01 -> cpu_en=1 only at cycle 11; state STEP at 11, STOP at 12; instr_count=1.
- btn_run from STOP, op_code=8'h00, bp_en=0 -> cpu_en pulses every 4th cycle (first at 4 cycles after RUN entry); after 3 pulses instr_count=3; btn_stop -> no further pulses, state=0.
- RUN with bp_en=1, bp_addr=5, pc stepping 4->5 -> pulse at pc=4, none at pc=5; state=STOP. Re-run -> first issue at pc=5 pulses (skip_bp), then normal.
- RUN with pc=6, op_code=8'h86 (J, target 6) -> no pulse at issue point; state=HALT, halted=1. btn_run ignored; btn_stop -> STOP, halted=0.
- btn_stop asserted in the prescaler==3 cycle during RUN -> cpu_en stays 0, state=STOP; btn_run and btn_step together in STOP -> RUN.
- instr_count preset by 255 steps -> next pulse wraps it to 0. reset_n low mid-RUN -> all outputs 0 asynchronously.
